// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for the registered ALU: default datapath
//            width and the 4-bit operation-select encodings.
// Ports    : (package - no ports)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLL   = 4'd9;
    localparam logic [3:0] OP_SRL   = 4'd10;
    localparam logic [3:0] OP_SRA   = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_SLTU  = 4'd13;
    localparam logic [3:0] OP_PASSA = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module   : alu_shifter
// Purpose  : Combinational barrel shifter producing all three shift flavours
//            in parallel; the ALU picks the one it needs.
// Ports    : a_i      [WIDTH-1:0]   value to shift
//            shamt_i  [SHW-1:0]     shift amount
//            sll_o    [WIDTH-1:0]   logical left shift
//            srl_o    [WIDTH-1:0]   logical right shift
//            sra_o    [WIDTH-1:0]   arithmetic right shift (sign-filling)
// Revision : 1.0 - initial release
// ============================================================================
module alu_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [SHW-1:0]   shamt_i,
    output logic [WIDTH-1:0] sll_o,
    output logic [WIDTH-1:0] srl_o,
    output logic [WIDTH-1:0] sra_o
);

    assign sll_o = a_i << shamt_i;
    assign srl_o = a_i >> shamt_i;
    assign sra_o = $unsigned($signed(a_i) >>> shamt_i);

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Registered two's-complement ALU. The result of (a, b, sel)
//            sampled on a rising edge appears on out after that edge and is
//            held until the next one. Reset clears out asynchronously.
// Ports    : clk  in   1       rising-edge clock
//            rst  in   1       asynchronous active-high reset
//            a    in   WIDTH   signed operand A
//            b    in   WIDTH   signed operand B
//            sel  in   4       operation select (see alu_pkg OP_*)
//            out  out  WIDTH   registered result
// Revision : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] sll_w;
    logic [WIDTH-1:0] srl_w;
    logic [WIDTH-1:0] sra_w;
    logic             slt_w;
    logic             sltu_w;

    // Only the low log2(WIDTH) bits of b steer the shifter.
    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .a_i     (a),
        .shamt_i (b[SHW-1:0]),
        .sll_o   (sll_w),
        .srl_o   (srl_w),
        .sra_o   (sra_w)
    );

    assign slt_w  = ($signed(a) < $signed(b));
    assign sltu_w = (a < b);

    // Any select value not matching an opcode (including X/Z in simulation)
    // falls to the default and yields zero rather than propagating X.
    always_comb begin
        out_d = '0;
        case (sel)
            OP_NOP:   out_d = '0;
            OP_ADD:   out_d = a + b;
            OP_SUB:   out_d = a - b;
            OP_MUL:   out_d = a * b;  // low WIDTH bits are sign-agnostic
            OP_AND:   out_d = a & b;
            OP_OR:    out_d = a | b;
            OP_XOR:   out_d = a ^ b;
            OP_NOT:   out_d = ~a;
            OP_SLT:   out_d = {{(WIDTH-1){1'b0}}, slt_w};
            OP_SLL:   out_d = sll_w;
            OP_SRL:   out_d = srl_w;
            OP_SRA:   out_d = sra_w;
            OP_NOR:   out_d = ~(a | b);
            OP_SLTU:  out_d = {{(WIDTH-1){1'b0}}, sltu_w};
            OP_PASSA: out_d = a;
            OP_PASSB: out_d = b;
            default:  out_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Self-checking bench for alu: directed vector table, reset and
//            unknown-select sequences, then random operations compared
//            against an arithmetic reference model.
// Ports    : (none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive operands mid-cycle, let one rising edge capture them, sample after it.
    task automatic apply(input logic [3:0] s, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        sel = s;
        a   = va;
        b   = vb;
        @(posedge clk);
        #1;
    endtask

    // Reference: computed from the operation definitions with 64-bit integer
    // arithmetic, powers of two and floor division, then truncated to 32 bits.
    function automatic logic [31:0] ref_model(input logic [3:0] s, input logic [31:0] va, input logic [31:0] vb);
        longint sa, sb, ua, ub, pw, r;
        int     sh;
        logic [63:0] rv;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        ua = longint'({32'd0, va});
        ub = longint'({32'd0, vb});
        sh = int'(vb % 32);
        pw = 1;
        for (int i = 0; i < sh; i++) pw = pw * 2;
        case (s)
            4'd1:    r = sa + sb;
            4'd2:    r = sa - sb;
            4'd3:    r = sa * sb;
            4'd4:    r = longint'({32'd0, va & vb});
            4'd5:    r = longint'({32'd0, va | vb});
            4'd6:    r = longint'({32'd0, va ^ vb});
            4'd7:    r = longint'({32'd0, ~va});
            4'd8:    r = (sa < sb) ? 1 : 0;
            4'd9:    r = ua * pw;
            4'd10:   r = ua / pw;
            4'd11:   r = (sa >= 0) ? (sa / pw) : -((-sa + pw - 1) / pw);
            4'd12:   r = longint'({32'd0, ~(va | vb)});
            4'd13:   r = (ua < ub) ? 1 : 0;
            4'd14:   r = ua;
            4'd15:   r = ub;
            default: r = 0;
        endcase
        rv = r;
        return rv[31:0];
    endfunction

    vec_t vecs[23];

    initial begin
        logic [3:0]  rs;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs = '{
            '{4'd1,  32'd5,        32'd2,        32'd7},
            '{4'd2,  32'd5,        32'd2,        32'd3},
            '{4'd3,  32'd5,        32'd2,        32'd10},
            '{4'd4,  32'd5,        32'd2,        32'd0},
            '{4'd5,  32'd5,        32'd2,        32'd7},
            '{4'd6,  32'd5,        32'd2,        32'd7},
            '{4'd7,  32'd5,        32'd2,        32'hFFFFFFFA},
            '{4'd8,  32'd5,        32'd2,        32'd0},
            '{4'd8,  32'd10,       32'd5,        32'd0},
            '{4'd8,  32'hFFFFFFF6, 32'd13,       32'd1},
            '{4'd13, 32'hFFFFFFF6, 32'd13,       32'd0},
            '{4'd9,  32'hFFFFFFF6, 32'd2,        32'hFFFFFFD8},
            '{4'd10, 32'hFFFFFFF6, 32'd2,        32'h3FFFFFFD},
            '{4'd11, 32'hFFFFFFF6, 32'd2,        32'hFFFFFFFD},
            '{4'd9,  32'hFFFFFFF6, 32'd34,       32'hFFFFFFD8},
            '{4'd10, 32'hFFFFFFF6, 32'd34,       32'h3FFFFFFD},
            '{4'd11, 32'hFFFFFFF6, 32'd34,       32'hFFFFFFFD},
            '{4'd1,  32'h7FFFFFFF, 32'd1,        32'h80000000},
            '{4'd3,  32'h00010000, 32'h00010000, 32'd0},
            '{4'd0,  32'd5,        32'd2,        32'd0},
            '{4'd14, 32'h12345678, 32'h9ABCDEF0, 32'h12345678},
            '{4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0},
            '{4'd12, 32'd5,        32'd2,        32'hFFFFFFF8}
        };

        // Reset state
        rst = 1'b1;
        sel = 4'd1;
        a   = 32'd5;
        b   = 32'd2;
        #1;
        check("reset_async_t0", out, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held_edge", out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table on consecutive cycles (operands change every edge)
        foreach (vecs[i]) begin
            apply(vecs[i].sel, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_sel%0d", i, vecs[i].sel), out, vecs[i].exp);
        end

        // Result holds between edges
        apply(4'd1, 32'd5, 32'd2);
        check("add_before_rst", out, 32'd7);
        #2;
        check("hold_between_edges", out, 32'd7);

        // Asynchronous reset mid-cycle, held through edges, then release
        rst = 1'b1;
        #1;
        check("rst_async_mid", out, 32'd0);
        @(posedge clk);
        #1;
        check("rst_held_1", out, 32'd0);
        @(posedge clk);
        #1;
        check("rst_held_2", out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_load", out, 32'd7);

        // Unknown select yields zero
        apply(4'd14, 32'hDEADBEEF, 32'd0);
        check("passa_pre_x", out, 32'hDEADBEEF);
        apply(4'bxxxx, 32'hDEADBEEF, 32'd3);
        check("sel_x_zero", out, 32'd0);

        // Random operations against the reference model
        for (int i = 0; i < 400; i++) begin
            rs = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            apply(rs, ra, rb);
            check($sformatf("rand%0d_sel%0d", i, rs), out, ref_model(rs, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
